// File: rtl/tomasulo_rs_arith.sv
// Reservation station for the arithmetic execution unit.
// Holds ADD/SUB/MOV ops until both operands are valid, snoops the CDB for
// outstanding producer tags, and issues the oldest ready entry each cycle.
package tomasulo_rs_arith_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MOV = 2'd2} opcode_t;
  typedef logic [3:0]  tag_t;
  typedef logic [3:0]  robid_t;
  typedef logic [4:0]  wa_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    logic   vld;
    tag_t   tag;
    word_t  wdata;
    robid_t robid;
    wa_t    wa;
  } cdb_t;

  typedef struct packed {
    opcode_t     op;
    tag_t        tag;
    word_t [1:0] rdata;
    robid_t      robid;
    wa_t         wa;
  } issue_t;
endpackage

module tomasulo_rs_arith
  import tomasulo_rs_arith_pkg::*;
#(
  parameter  int N     = 4,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_vld,
  output logic             disp_rdy,
  input  opcode_t          disp_op,
  input  tag_t             disp_tag,
  input  robid_t           disp_robid,
  input  wa_t              disp_wa,
  input  logic [1:0]       disp_src_rdy,
  input  tag_t [1:0]       disp_src_tag,
  input  word_t [1:0]      disp_src_data,
  input  cdb_t             cdb_r,
  output logic             iss_vld,
  output issue_t           iss,
  output logic [CNT_W-1:0] occ_r
);
  localparam int IDX_W = $clog2(N);

  // Entry storage. r_age[i][j] = 1 means entry i is older than entry j.
  logic [N-1:0]  r_vld;
  opcode_t       r_op       [N];
  tag_t          r_tag      [N];
  robid_t        r_robid    [N];
  wa_t           r_wa       [N];
  logic [1:0]    r_src_rdy  [N];
  tag_t [1:0]    r_src_tag  [N];
  word_t [1:0]   r_src_data [N];
  logic [N-1:0]  r_age      [N];

  logic [N-1:0]     w_ready;
  logic [N-1:0]     w_sel;
  logic             w_iss_fire;
  logic             w_disp_fire;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_free_found;
  logic             w_tag_dup;
  logic             w_age_bad;
  logic             w_unused_cdb;

  assign w_unused_cdb = ^{cdb_r.robid, cdb_r.wa};

  // Dispatch acceptance depends only on registered occupancy and reset.
  assign disp_rdy    = !rst && (occ_r != CNT_W'(N));
  assign w_disp_fire = disp_vld && disp_rdy && !flush;

  // Ready vector and oldest-ready selection via the age matrix.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_ready = '0;
    w_sel   = '0;
    for (int i = 0; i < N; i++) w_ready[i] = r_vld[i] && (&r_src_rdy[i]);
    for (int i = 0; i < N; i++) begin
      w_sel[i] = w_ready[i];
      for (int j = 0; j < N; j++)
        if (j != i && w_ready[j] && r_age[j][i]) w_sel[i] = 1'b0;
    end
  end

  assign w_iss_fire = (|w_ready) && !flush;
  assign iss_vld    = w_iss_fire;

  // Issue payload muxed from the selected entry; zero when nothing issues.
  always_comb begin
    iss = '0;
    for (int i = 0; i < N; i++) begin
      if (w_iss_fire && w_sel[i]) begin
        iss.op    = r_op[i];
        iss.tag   = r_tag[i];
        iss.rdata = r_src_data[i];
        iss.robid = r_robid[i];
        iss.wa    = r_wa[i];
      end
    end
  end

  // Lowest-index free slot (descending scan leaves the lowest match).
  always_comb begin
    w_free_idx   = '0;
    w_free_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!r_vld[i]) begin
        w_free_idx   = IDX_W'(i);
        w_free_found = 1'b1;
      end
    end
  end

  // Entry state update: flush/reset, CDB wakeup, issue retire, dispatch allocate.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all entries update from the same pre-edge view.
    if (rst || flush) begin
      // NOTE: only valid bits and age are cleared; payload is don't-care while an entry is invalid.
      r_vld <= '0;
      occ_r <= '0;
      for (int i = 0; i < N; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < 2; s++) begin
          if (r_vld[i] && !r_src_rdy[i][s] && cdb_r.vld && (r_src_tag[i][s] == cdb_r.tag)) begin
            r_src_rdy[i][s]  <= 1'b1;
            r_src_data[i][s] <= cdb_r.wdata;
          end
        end
      end

      for (int i = 0; i < N; i++) begin
        if (w_iss_fire && w_sel[i]) begin
          r_vld[i] <= 1'b0;
          r_age[i] <= '0;
          for (int j = 0; j < N; j++) r_age[j][i] <= 1'b0;
        end
      end

      if (w_disp_fire) begin
        r_vld[w_free_idx]     <= 1'b1;
        r_op[w_free_idx]      <= disp_op;
        r_tag[w_free_idx]     <= disp_tag;
        r_robid[w_free_idx]   <= disp_robid;
        r_wa[w_free_idx]      <= disp_wa;
        r_src_tag[w_free_idx] <= disp_src_tag;
        r_age[w_free_idx]     <= '0;
        for (int j = 0; j < N; j++)
          r_age[j][w_free_idx] <= r_vld[j] && !(w_iss_fire && w_sel[j]);
        for (int s = 0; s < 2; s++) begin
          if (disp_src_rdy[s]) begin
            r_src_rdy[w_free_idx][s]  <= 1'b1;
            r_src_data[w_free_idx][s] <= disp_src_data[s];
          end else if (cdb_r.vld && (disp_src_tag[s] == cdb_r.tag)) begin
            r_src_rdy[w_free_idx][s]  <= 1'b1;
            r_src_data[w_free_idx][s] <= cdb_r.wdata;
          end else begin
            r_src_rdy[w_free_idx][s]  <= 1'b0;
            r_src_data[w_free_idx][s] <= disp_src_data[s];
          end
        end
      end

      occ_r <= occ_r + CNT_W'(w_disp_fire) - CNT_W'(w_iss_fire);
    end
  end

  // Structural invariants: unique tags and antisymmetric age over valid entries.
  always_comb begin
    w_tag_dup = 1'b0;
    w_age_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i != j && r_vld[i] && r_vld[j]) begin
          if (r_tag[i] == r_tag[j]) w_tag_dup = 1'b1;
          if (r_age[i][j] == r_age[j][i]) w_age_bad = 1'b1;
        end
      end
    end
  end

  a_tag_unique : assert property (@(posedge clk) disable iff (rst) !w_tag_dup);
  a_age_anti   : assert property (@(posedge clk) disable iff (rst) !w_age_bad);
  a_one_issue  : assert property (@(posedge clk) disable iff (rst) $countones(w_sel) <= 1);
  a_occ_max    : assert property (@(posedge clk) disable iff (rst) occ_r <= CNT_W'(N));
  a_occ_match  : assert property (@(posedge clk) disable iff (rst) occ_r == CNT_W'($countones(r_vld)));
  a_free_slot  : assert property (@(posedge clk) disable iff (rst) disp_rdy |-> w_free_found);

endmodule

// File: tb/tb_tomasulo_rs_arith.sv
// Directed testbench for tomasulo_rs_arith: dispatch, wakeup, age ordering,
// bypass, full/flush/reset behaviour, with hand-computed expectations.
module tb_tomasulo_rs_arith;
  import tomasulo_rs_arith_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = $clog2(N + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             disp_vld;
  logic             disp_rdy;
  opcode_t          disp_op;
  tag_t             disp_tag;
  robid_t           disp_robid;
  wa_t              disp_wa;
  logic [1:0]       disp_src_rdy;
  tag_t [1:0]       disp_src_tag;
  word_t [1:0]      disp_src_data;
  cdb_t             cdb_r;
  logic             iss_vld;
  issue_t           iss;
  logic [CNT_W-1:0] occ_r;

  int n_checks = 0;
  int n_fail   = 0;

  tomasulo_rs_arith #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_vld      (disp_vld),
    .disp_rdy      (disp_rdy),
    .disp_op       (disp_op),
    .disp_tag      (disp_tag),
    .disp_robid    (disp_robid),
    .disp_wa       (disp_wa),
    .disp_src_rdy  (disp_src_rdy),
    .disp_src_tag  (disp_src_tag),
    .disp_src_data (disp_src_data),
    .cdb_r         (cdb_r),
    .iss_vld       (iss_vld),
    .iss           (iss),
    .occ_r         (occ_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush         = 1'b0;
    disp_vld      = 1'b0;
    disp_op       = OP_ADD;
    disp_tag      = '0;
    disp_robid    = '0;
    disp_wa       = '0;
    disp_src_rdy  = '0;
    disp_src_tag  = '0;
    disp_src_data = '0;
    cdb_r         = '0;
  endtask

  task automatic set_disp(input opcode_t op, input int tag, input int robid, input int wa,
                          input logic [1:0] srdy, input int t0, input int t1,
                          input int d0, input int d1);
    disp_vld         = 1'b1;
    disp_op          = op;
    disp_tag         = tag_t'(tag);
    disp_robid       = robid_t'(robid);
    disp_wa          = wa_t'(wa);
    disp_src_rdy     = srdy;
    disp_src_tag[0]  = tag_t'(t0);
    disp_src_tag[1]  = tag_t'(t1);
    disp_src_data[0] = word_t'(d0);
    disp_src_data[1] = word_t'(d1);
  endtask

  task automatic set_cdb(input int tag, input int wdata);
    cdb_r       = '0;
    cdb_r.vld   = 1'b1;
    cdb_r.tag   = tag_t'(tag);
    cdb_r.wdata = word_t'(wdata);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (disp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_disp_rdy got=%0b exp=0", disp_rdy); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (occ_r !== 0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occ_r); end
    n_checks++;
    if (iss_vld !== 1'b0) begin n_fail++; $display("FAIL reset_iss_vld got=%0b exp=0", iss_vld); end
    n_checks++;
    if (iss !== '0) begin n_fail++; $display("FAIL reset_iss got=%h exp=0", iss); end
    n_checks++;
    if (disp_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_disp_rdy_after got=%0b exp=1", disp_rdy); end
  endtask

  // Both sources ready: issue the very next cycle with rdata={7,5}; exe sum is 12.
  task automatic test_single_issue();
    set_disp(OP_ADD, 3, 1, 5, 2'b11, 0, 0, 5, 7);
    #1;
    n_checks++;
    if (iss_vld !== 1'b0) begin n_fail++; $display("FAIL t1_no_early got=%0b exp=0", iss_vld); end
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.op !== OP_ADD || iss.tag !== 4'd3 || iss.robid !== 4'd1 || iss.wa !== 5'd5)
      begin n_fail++; $display("FAIL t1_issue vld=%0b op=%0d tag=%0d robid=%0d wa=%0d exp vld=1 op=0 tag=3 robid=1 wa=5",
                               iss_vld, iss.op, iss.tag, iss.robid, iss.wa); end
    n_checks++;
    if (iss.rdata[1] !== 32'd7 || iss.rdata[0] !== 32'd5)
      begin n_fail++; $display("FAIL t1_rdata got={%0d,%0d} exp={7,5}", iss.rdata[1], iss.rdata[0]); end
    n_checks++;
    if (iss.rdata[1] + iss.rdata[0] !== 32'd12)
      begin n_fail++; $display("FAIL t1_exe_sum got=%0d exp=12", iss.rdata[1] + iss.rdata[0]); end
    n_checks++;
    if (occ_r !== 1) begin n_fail++; $display("FAIL t1_occ got=%0d exp=1", occ_r); end
    step();
    n_checks++;
    if (iss_vld !== 1'b0 || occ_r !== 0)
      begin n_fail++; $display("FAIL t1_drain vld=%0b occ=%0d exp vld=0 occ=0", iss_vld, occ_r); end
  endtask

  // src0 waits on tag 2; CDB at t wakes it and issue follows at t+1, never earlier.
  task automatic test_wakeup();
    set_disp(OP_SUB, 7, 2, 6, 2'b10, 2, 0, 0, 4);
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b0 || occ_r !== 1)
      begin n_fail++; $display("FAIL t2_wait vld=%0b occ=%0d exp vld=0 occ=1", iss_vld, occ_r); end
    step();
    set_cdb(2, 10);
    #1;
    n_checks++;
    if (iss_vld !== 1'b0) begin n_fail++; $display("FAIL t2_same_cycle got=%0b exp=0", iss_vld); end
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.op !== OP_SUB || iss.tag !== 4'd7 || iss.rdata[0] !== 32'd10 || iss.rdata[1] !== 32'd4)
      begin n_fail++; $display("FAIL t2_issue vld=%0b op=%0d tag=%0d rdata={%0d,%0d} exp vld=1 op=1 tag=7 rdata={4,10}",
                               iss_vld, iss.op, iss.tag, iss.rdata[1], iss.rdata[0]); end
    step();
    n_checks++;
    if (occ_r !== 0) begin n_fail++; $display("FAIL t2_drain occ got=%0d exp=0", occ_r); end
  endtask

  // Dispatch while the previous op issues: occupancy holds at 1.
  task automatic test_back_to_back();
    set_disp(OP_ADD, 1, 3, 1, 2'b11, 0, 0, 1, 2);
    step();
    set_disp(OP_SUB, 2, 4, 2, 2'b11, 0, 0, 3, 4);
    #1;
    n_checks++;
    if (iss_vld !== 1'b1 || iss.tag !== 4'd1)
      begin n_fail++; $display("FAIL b2b_first vld=%0b tag=%0d exp vld=1 tag=1", iss_vld, iss.tag); end
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.tag !== 4'd2 || iss.rdata[0] !== 32'd3 || iss.rdata[1] !== 32'd4 || occ_r !== 1)
      begin n_fail++; $display("FAIL b2b_second vld=%0b tag=%0d rdata={%0d,%0d} occ=%0d exp vld=1 tag=2 rdata={4,3} occ=1",
                               iss_vld, iss.tag, iss.rdata[1], iss.rdata[0], occ_r); end
    step();
    n_checks++;
    if (occ_r !== 0 || iss_vld !== 1'b0)
      begin n_fail++; $display("FAIL b2b_drain occ=%0d vld=%0b exp occ=0 vld=0", occ_r, iss_vld); end
  endtask

  // Fill all entries, dispatch while full is dropped, one issue frees a slot a cycle later.
  task automatic test_full();
    for (int k = 0; k < N; k++) begin
      set_disp(OP_ADD, 8 + k, k, k, 2'b10, 12 + k, 0, 0, k);
      step();
    end
    clear_inputs();
    n_checks++;
    if (occ_r !== 4 || disp_rdy !== 1'b0)
      begin n_fail++; $display("FAIL t3_full occ=%0d rdy=%0b exp occ=4 rdy=0", occ_r, disp_rdy); end
    set_disp(OP_MOV, 1, 9, 9, 2'b11, 0, 0, 11, 11);
    step();
    clear_inputs();
    n_checks++;
    if (occ_r !== 4 || iss_vld !== 1'b0)
      begin n_fail++; $display("FAIL t3_ignored occ=%0d vld=%0b exp occ=4 vld=0", occ_r, iss_vld); end
    set_cdb(13, 100);
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.tag !== 4'd9 || iss.rdata[0] !== 32'd100 || iss.rdata[1] !== 32'd1 || disp_rdy !== 1'b0)
      begin n_fail++; $display("FAIL t3_issue vld=%0b tag=%0d rdata={%0d,%0d} rdy=%0b exp vld=1 tag=9 rdata={1,100} rdy=0",
                               iss_vld, iss.tag, iss.rdata[1], iss.rdata[0], disp_rdy); end
    step();
    n_checks++;
    if (occ_r !== 3 || disp_rdy !== 1'b1 || iss_vld !== 1'b0)
      begin n_fail++; $display("FAIL t3_freed occ=%0d rdy=%0b vld=%0b exp occ=3 rdy=1 vld=0", occ_r, disp_rdy, iss_vld); end
    flush = 1'b1;
    step();
    clear_inputs();
    n_checks++;
    if (occ_r !== 0) begin n_fail++; $display("FAIL t3_cleanup occ got=%0d exp=0", occ_r); end
  endtask

  // Older A sits in a higher slot than younger B; a shared wakeup issues A first.
  task automatic test_age();
    set_disp(OP_ADD, 4, 0, 0, 2'b10, 14, 0, 0, 0);  // X -> slot0
    step();
    set_disp(OP_ADD, 1, 1, 1, 2'b10, 5, 0, 0, 50);  // A -> slot1
    step();
    clear_inputs();
    set_cdb(14, 1);
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.tag !== 4'd4)
      begin n_fail++; $display("FAIL t4_x_issue vld=%0b tag=%0d exp vld=1 tag=4", iss_vld, iss.tag); end
    step();
    set_disp(OP_SUB, 2, 2, 2, 2'b10, 5, 0, 0, 60);  // B -> slot0, younger
    step();
    clear_inputs();
    n_checks++;
    if (occ_r !== 2 || iss_vld !== 1'b0)
      begin n_fail++; $display("FAIL t4_setup occ=%0d vld=%0b exp occ=2 vld=0", occ_r, iss_vld); end
    set_cdb(5, 33);
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.tag !== 4'd1 || iss.rdata[0] !== 32'd33 || iss.rdata[1] !== 32'd50)
      begin n_fail++; $display("FAIL t4_a_first vld=%0b tag=%0d rdata={%0d,%0d} exp vld=1 tag=1 rdata={50,33}",
                               iss_vld, iss.tag, iss.rdata[1], iss.rdata[0]); end
    step();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.tag !== 4'd2 || iss.rdata[0] !== 32'd33 || iss.rdata[1] !== 32'd60 || occ_r !== 1)
      begin n_fail++; $display("FAIL t4_b_second vld=%0b tag=%0d rdata={%0d,%0d} occ=%0d exp vld=1 tag=2 rdata={60,33} occ=1",
                               iss_vld, iss.tag, iss.rdata[1], iss.rdata[0], occ_r); end
    step();
    n_checks++;
    if (occ_r !== 0 || iss_vld !== 1'b0)
      begin n_fail++; $display("FAIL t4_drain occ=%0d vld=%0b exp occ=0 vld=0", occ_r, iss_vld); end
  endtask

  // Both sources captured from a coincident CDB broadcast at dispatch.
  task automatic test_bypass();
    set_disp(OP_MOV, 3, 5, 7, 2'b00, 6, 6, 0, 0);
    set_cdb(6, 9);
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.op !== OP_MOV || iss.tag !== 4'd3 || iss.rdata[0] !== 32'd9 || iss.rdata[1] !== 32'd9)
      begin n_fail++; $display("FAIL t5_bypass vld=%0b op=%0d tag=%0d rdata={%0d,%0d} exp vld=1 op=2 tag=3 rdata={9,9}",
                               iss_vld, iss.op, iss.tag, iss.rdata[1], iss.rdata[0]); end
    step();
    n_checks++;
    if (occ_r !== 0) begin n_fail++; $display("FAIL t5_drain occ got=%0d exp=0", occ_r); end
  endtask

  // Flush beats a ready entry's issue and a concurrent dispatch.
  task automatic test_flush();
    set_disp(OP_ADD, 1, 1, 1, 2'b10, 14, 0, 0, 1);
    step();
    set_disp(OP_ADD, 2, 2, 2, 2'b10, 13, 0, 0, 2);
    step();
    set_disp(OP_ADD, 3, 3, 3, 2'b10, 12, 0, 0, 3);
    step();
    clear_inputs();
    set_cdb(12, 77);
    step();
    clear_inputs();
    n_checks++;
    if (iss_vld !== 1'b1 || iss.tag !== 4'd3 || occ_r !== 3)
      begin n_fail++; $display("FAIL t6_pre vld=%0b tag=%0d occ=%0d exp vld=1 tag=3 occ=3", iss_vld, iss.tag, occ_r); end
    flush = 1'b1;
    set_disp(OP_ADD, 4, 4, 4, 2'b11, 0, 0, 8, 8);
    #1;
    n_checks++;
    if (iss_vld !== 1'b0 || iss !== '0)
      begin n_fail++; $display("FAIL t6_suppress vld=%0b iss=%h exp vld=0 iss=0", iss_vld, iss); end
    step();
    clear_inputs();
    n_checks++;
    if (occ_r !== 0 || iss_vld !== 1'b0)
      begin n_fail++; $display("FAIL t6_after occ=%0d vld=%0b exp occ=0 vld=0", occ_r, iss_vld); end
    step();
    n_checks++;
    if (iss_vld !== 1'b0 || occ_r !== 0)
      begin n_fail++; $display("FAIL t6_dropped vld=%0b occ=%0d exp vld=0 occ=0", iss_vld, occ_r); end
  endtask

  // Reset in the middle of operation clears entries and blocks dispatch.
  task automatic test_reset_mid();
    set_disp(OP_ADD, 5, 1, 1, 2'b11, 0, 0, 2, 3);
    step();
    clear_inputs();
    rst = 1'b1;
    #1;
    n_checks++;
    if (disp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rdy got=%0b exp=0", disp_rdy); end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (occ_r !== 0 || iss_vld !== 1'b0 || disp_rdy !== 1'b1)
      begin n_fail++; $display("FAIL rst_mid_after occ=%0d vld=%0b rdy=%0b exp occ=0 vld=0 rdy=1",
                               occ_r, iss_vld, disp_rdy); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_issue();
    test_wakeup();
    test_back_to_back();
    test_full();
    test_age();
    test_bypass();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
